iob_timer_alarm_ctrl: RTL and testbench
=======================================

Name: iob_timer_alarm_ctrl

Overview:
- Multi-channel alarm scheduler that sits beside the 64-bit free-running timer core and consumes its time value.
- Holds N_CH armed 64-bit deadlines and shares one 64-bit magnitude comparator among them through a round-robin scan.
- Sets a per-channel pending flag and a combined interrupt when a deadline is reached.
- Configured by a simple write port driven from the software register file.

Parameters:
- N_CH, 4: number of alarm channels, 2..16.
- DATA_W, 32: CPU data width; time and deadlines are 2*DATA_W bits.
- CH_W, $clog2(N_CH): localparam, channel index width.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- cke_i  in  1  clock enable; when low, all state is frozen.
- time_i  in  2*DATA_W  current count from the timer core.
- cfg_we_i  in  1  config write strobe.
- cfg_op_i  in  2  0=DL_LOW, 1=DL_HIGH_ARM, 2=DISARM, 3=PERIOD.
- cfg_ch_i  in  CH_W  target channel.
- cfg_wdata_i  in  DATA_W  write data.
- irq_ack_i  in  N_CH  per-channel pending clear (one-cycle pulses).
- armed_o  out  N_CH  channel armed flags.
- pending_o  out  N_CH  channel fired flags.
- irq_o  out  1  OR of pending_o.
- scan_ch_o  out  CH_W  channel compared in this cycle.

Behaviour:
- Reset (rst_i high at a clk_i edge, regardless of cke_i):
  - armed_o=0, pending_o=0, irq_o=0, scan_ch_o=0.
  - All deadlines=0, staging register=0, periods=0.
  - Any in-progress staging or scan is discarded.
- All other updates happen only on edges with cke_i=1.
- Scan pointer:
  - Increments each enabled cycle: 0,1,...,N_CH-1,0.
  - Wraps explicitly when N_CH is not a power of 2.
- Compare:
  - Each cycle: hit = armed[scan_ch] && (time_i >= deadline[scan_ch]), 64-bit unsigned.
  - On hit, at the next edge: pending[scan_ch]<=1 and armed[scan_ch]<=0. Periodic case is under Optional Feature.
  - Equality fires.
  - Detection latency after time_i first satisfies the compare: 1 to N_CH cycles.
- Config (cfg_we_i=1):
  - DL_LOW: staging_low<=cfg_wdata_i (single shared staging register, not per channel).
  - DL_HIGH_ARM: deadline[ch]<={cfg_wdata_i, staging_low}, armed[ch]<=1; pending[ch] unchanged.
  - DISARM: armed[ch]<=0.
  - PERIOD: see Optional Feature.
  - Config writes are accepted every enabled cycle; there is no backpressure.
- Collision, config write to the channel currently scanned:
  - The config write wins.
  - That cycle's hit for that channel is discarded; no pending is set and armed follows the write.
  - The channel is re-evaluated on its next visit.
- Simultaneous set and ack on the same channel: set wins, so pending stays 1.
- irq_ack_i bits for non-pending channels have no effect.
- irq_o is registered: equals |pending_o in the same cycle.
- Deadline already in the past when armed: fires on the channel's next scan visit.
- Timer soft reset (time_i drops): armed channels wait for the new count; no special handling.
- 64-bit wrap is not handled.

Optional Feature:
- Macro: IOB_TIMER_ALARM_PERIODIC_EN.
- Defined:
  - Per-channel DATA_W period register; PERIOD op writes period[ch]<=cfg_wdata_i.
  - On hit with period[ch]!=0: pending<=1, deadline<=deadline+zero_extend(period), armed stays 1.
  - On hit with period[ch]==0: one-shot behaviour.
  - DL_HIGH_ARM does not change the period.
- Undefined:
  - No period storage.
  - PERIOD op is a no-op.
  - All alarms are one-shot.

Test Plan:
- Reset, N_CH=4: pulse rst_i with cke_i=1 -> armed/pending/irq=0; scan_ch_o sequence 0,1,2,3,0,1; with cke_i=0, scan_ch_o holds.
- Arm ch2: DL_LOW 0x00000010, DL_HIGH_ARM 0x00000001; ramp time_i from 0x1_00000000 -> pending_o[2]=1 within 1..4 cycles of time_i reaching 0x1_00000010, never earlier; armed_o[2]=0; irq_o=1.
- Past deadline: time_i=100, arm ch0 with deadline 5 -> pending_o[0] on the next visit to ch0 (at most 4 cycles); ack ch0 -> pending_o[0]=0, irq_o=0.
- Ack collision: irq_ack_i[1] in the same cycle ch1 hits -> pending_o[1] remains 1.
- Config collision: ch3 armed at deadline 50 with time_i=60; issue DL_HIGH_ARM to ch3 (new deadline 1000) exactly when scan_ch_o=3 -> no fire; armed_o[3]=1; fires only after time_i>=1000.
- IOB_TIMER_ALARM_PERIODIC_EN: ch1 period 10, deadline 20, ack after each fire -> pending at time 20, 30, 40 (each within 4 cycles); armed_o[1] stays 1. Without macro: single fire at 20, then armed_o[1]=0.

Source files
------------

// File: rtl/iob_timer_alarm_ctrl.sv
// Multi-channel alarm scheduler: N_CH 64-bit deadlines checked against time_i by one shared
// comparator scanned round-robin. Define IOB_TIMER_ALARM_PERIODIC_EN for auto-rearming periodic alarms.
module iob_timer_alarm_ctrl #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    input  logic [2*DATA_W-1:0] time_i,
    input  logic                cfg_we_i,
    input  logic [1:0]          cfg_op_i,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic [DATA_W-1:0]   cfg_wdata_i,
    input  logic [N_CH-1:0]     irq_ack_i,
    output logic [N_CH-1:0]     armed_o,
    output logic [N_CH-1:0]     pending_o,
    output logic                irq_o,
    output logic [CH_W-1:0]     scan_ch_o
);

    localparam int T_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        OP_DL_LOW      = 2'd0,
        OP_DL_HIGH_ARM = 2'd1,
        OP_DISARM      = 2'd2,
        OP_PERIOD      = 2'd3
    } cfg_op_e;

    cfg_op_e           op;
    logic [CH_W-1:0]   scan_q, scan_d;
    logic [N_CH-1:0]   armed_q, armed_d;
    logic [N_CH-1:0]   pending_q, pending_d;
    logic [N_CH-1:0]   set_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] staging_q, staging_d;
    logic [T_W-1:0]    deadline_q [N_CH];
    logic [T_W-1:0]    deadline_d [N_CH];
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
    logic [DATA_W-1:0] period_q [N_CH];
    logic [DATA_W-1:0] period_d [N_CH];
`endif
    logic              hit;
    logic              cfg_on_scan;

    always_comb begin
        op        = cfg_op_e'(cfg_op_i);
        scan_d    = (scan_q == CH_W'(N_CH - 1)) ? '0 : scan_q + 1'b1;
        hit       = armed_q[scan_q] && (time_i >= deadline_q[scan_q]);
        armed_d   = armed_q;
        set_d     = '0;
        staging_d = staging_q;
        deadline_d = deadline_q;
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
        period_d    = period_q;
        cfg_on_scan = cfg_we_i && (cfg_ch_i == scan_q) && (op != OP_DL_LOW);
`else
        cfg_on_scan = cfg_we_i && (cfg_ch_i == scan_q) &&
                      (op == OP_DL_HIGH_ARM || op == OP_DISARM);
`endif

        // A channel-targeting write to the scanned channel drops this cycle's hit;
        // the channel is simply re-evaluated on its next visit.
        if (hit && !cfg_on_scan) begin
            set_d[scan_q] = 1'b1;
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
            if (period_q[scan_q] != '0) begin
                deadline_d[scan_q] = deadline_q[scan_q] + T_W'(period_q[scan_q]);
            end else begin
                armed_d[scan_q] = 1'b0;
            end
`else
            armed_d[scan_q] = 1'b0;
`endif
        end

        if (cfg_we_i) begin
            case (op)
                OP_DL_LOW: staging_d = cfg_wdata_i;
                OP_DL_HIGH_ARM: begin
                    deadline_d[cfg_ch_i] = {cfg_wdata_i, staging_q};
                    armed_d[cfg_ch_i]    = 1'b1;
                end
                OP_DISARM: armed_d[cfg_ch_i] = 1'b0;
                OP_PERIOD: begin
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
                    period_d[cfg_ch_i] = cfg_wdata_i;
`endif
                end
                default: ;
            endcase
        end

        // Set beats a same-cycle acknowledge.
        pending_d = (pending_q & ~irq_ack_i) | set_d;
        irq_d     = |pending_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scan_q    <= '0;
            armed_q   <= '0;
            pending_q <= '0;
            irq_q     <= 1'b0;
            staging_q <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                deadline_q[i] <= '0;
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
                period_q[i]   <= '0;
`endif
            end
        end else if (cke_i) begin
            scan_q     <= scan_d;
            armed_q    <= armed_d;
            pending_q  <= pending_d;
            irq_q      <= irq_d;
            staging_q  <= staging_d;
            deadline_q <= deadline_d;
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
            period_q   <= period_d;
`endif
        end
    end

    assign armed_o   = armed_q;
    assign pending_o = pending_q;
    assign irq_o     = irq_q;
    assign scan_ch_o = scan_q;

endmodule

// File: tb/tb_iob_timer_alarm_ctrl.sv
// Directed self-checking bench for iob_timer_alarm_ctrl (N_CH=4, DATA_W=32); honours
// IOB_TIMER_ALARM_PERIODIC_EN when compiled with it.
module tb_iob_timer_alarm_ctrl;

    localparam logic [1:0] OP_LO  = 2'd0;
    localparam logic [1:0] OP_HI  = 2'd1;
    localparam logic [1:0] OP_DIS = 2'd2;
    localparam logic [1:0] OP_PER = 2'd3;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        cke_i = 1'b1;
    logic [63:0] time_i = '0;
    logic        cfg_we_i = 1'b0;
    logic [1:0]  cfg_op_i = '0;
    logic [1:0]  cfg_ch_i = '0;
    logic [31:0] cfg_wdata_i = '0;
    logic [3:0]  irq_ack_i = '0;
    logic [3:0]  armed_o;
    logic [3:0]  pending_o;
    logic        irq_o;
    logic [1:0]  scan_ch_o;

    int tests = 0;
    int fails = 0;

    iob_timer_alarm_ctrl #(.N_CH(4), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .cke_i(cke_i), .time_i(time_i),
        .cfg_we_i(cfg_we_i), .cfg_op_i(cfg_op_i), .cfg_ch_i(cfg_ch_i),
        .cfg_wdata_i(cfg_wdata_i), .irq_ack_i(irq_ack_i),
        .armed_o(armed_o), .pending_o(pending_o), .irq_o(irq_o), .scan_ch_o(scan_ch_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] op, input logic [1:0] ch, input logic [31:0] d);
        cfg_we_i = 1'b1; cfg_op_i = op; cfg_ch_i = ch; cfg_wdata_i = d;
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic ack(input logic [3:0] m);
        irq_ack_i = m;
        tick();
        irq_ack_i = '0;
    endtask

    task automatic wait_scan(input logic [1:0] ch, input string nm);
        int n = 0;
        while (scan_ch_o !== ch && n < 8) begin tick(); n++; end
        tests++;
        if (scan_ch_o !== ch) begin
            fails++; $display("FAIL %s: scan_ch_o=%0d required %0d", nm, scan_ch_o, ch);
        end
    endtask

    task automatic wait_pend(input int ch, input int maxc, input string nm);
        int n = 0;
        do begin tick(); n++; end while (pending_o[ch] !== 1'b1 && n < maxc);
        tests++;
        if (pending_o[ch] !== 1'b1) begin
            fails++; $display("FAIL %s: pending_o=%b after %0d cycles, required bit %0d set", nm, pending_o, n, ch);
        end
    endtask

    task automatic quiet(input int cycles, input logic [3:0] mask, input string nm);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if ((pending_o & mask) !== 4'b0) seen = 1'b1;
        end
        tests++;
        if (seen) begin fails++; $display("FAIL %s: early/unexpected pending, pending_o=%b required 0 on %b", nm, pending_o, mask); end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; cke_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tests += 4;
        if (armed_o !== 4'b0)   begin fails++; $display("FAIL rst_armed: %b required 0000", armed_o); end
        if (pending_o !== 4'b0) begin fails++; $display("FAIL rst_pending: %b required 0000", pending_o); end
        if (irq_o !== 1'b0)     begin fails++; $display("FAIL rst_irq: %b required 0", irq_o); end
        if (scan_ch_o !== 2'd0) begin fails++; $display("FAIL rst_scan: %0d required 0", scan_ch_o); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            tests++;
            if (scan_ch_o !== 2'(i % 4)) begin fails++; $display("FAIL scan_seq: %0d required %0d", scan_ch_o, i % 4); end
        end
        cke_i = 1'b0;
        repeat (3) tick();
        tests++;
        if (scan_ch_o !== 2'd1) begin fails++; $display("FAIL cke_hold_scan: %0d required 1", scan_ch_o); end
        cfg(OP_HI, 2'd0, 32'd0);
        tests++;
        if (armed_o !== 4'b0) begin fails++; $display("FAIL cke_hold_cfg: armed_o=%b required 0000", armed_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tests++;
        if (scan_ch_o !== 2'd0) begin fails++; $display("FAIL rst_no_cke: scan_ch_o=%0d required 0", scan_ch_o); end
        cke_i = 1'b1;
    endtask

    task automatic test_arm_ch2();
        time_i = 64'h1_0000_0000;
        cfg(OP_LO, 2'd0, 32'h0000_0010);
        cfg(OP_HI, 2'd2, 32'h0000_0001);
        tests++;
        if (armed_o !== 4'b0100) begin fails++; $display("FAIL arm_ch2: armed_o=%b required 0100", armed_o); end
        quiet(0, 4'b0100, "ramp_noop");
        begin
            logic early = 1'b0;
            for (int i = 0; i < 16; i++) begin
                time_i = 64'h1_0000_0000 + 64'(i);
                tick();
                if (pending_o[2] !== 1'b0) early = 1'b1;
            end
            tests++;
            if (early) begin fails++; $display("FAIL ramp_early: pending_o=%b required bit2 clear", pending_o); end
        end
        time_i = 64'h1_0000_0010;
        wait_pend(2, 4, "ch2_fire");
        tests += 2;
        if (armed_o[2] !== 1'b0) begin fails++; $display("FAIL ch2_disarmed: armed_o=%b required bit2 clear", armed_o); end
        if (irq_o !== 1'b1)      begin fails++; $display("FAIL ch2_irq: irq_o=%b required 1", irq_o); end
        ack(4'b0100);
        tests++;
        if (pending_o !== 4'b0 || irq_o !== 1'b0) begin
            fails++; $display("FAIL ch2_ack: pending_o=%b irq_o=%b required 0000/0", pending_o, irq_o);
        end
    endtask

    task automatic test_past_deadline();
        time_i = 64'd100;
        cfg(OP_LO, 2'd0, 32'd5);
        cfg(OP_HI, 2'd0, 32'd0);
        wait_pend(0, 4, "past_fire");
        ack(4'b0001);
        tests++;
        if (pending_o[0] !== 1'b0 || irq_o !== 1'b0) begin
            fails++; $display("FAIL past_ack: pending_o=%b irq_o=%b required bit0 clear/0", pending_o, irq_o);
        end
    endtask

    task automatic test_ack_collision();
        time_i = 64'd100;
        cfg(OP_LO, 2'd0, 32'd50);
        cfg(OP_HI, 2'd1, 32'd0);
        wait_pend(1, 4, "ch1_first_fire");
        wait_scan(2'd2, "ackcol_sync");
        cfg(OP_HI, 2'd1, 32'd0);
        tests++;
        if (pending_o[1] !== 1'b1 || armed_o[1] !== 1'b1) begin
            fails++; $display("FAIL rearm_keeps_pending: pending_o=%b armed_o=%b required bit1 set in both", pending_o, armed_o);
        end
        wait_scan(2'd1, "ackcol_visit");
        ack(4'b0010);
        tests += 2;
        if (pending_o[1] !== 1'b1) begin fails++; $display("FAIL ack_collision: pending_o=%b required bit1 set", pending_o); end
        if (armed_o[1] !== 1'b0)   begin fails++; $display("FAIL ack_col_armed: armed_o=%b required bit1 clear", armed_o); end
        ack(4'b0010);
        tests++;
        if (pending_o !== 4'b0) begin fails++; $display("FAIL ch1_clear: pending_o=%b required 0000", pending_o); end
    endtask

    task automatic test_cfg_collision();
        time_i = 64'd0;
        cfg(OP_LO, 2'd0, 32'd50);
        cfg(OP_HI, 2'd3, 32'd0);
        cfg(OP_LO, 2'd0, 32'd1000);
        wait_scan(2'd3, "cfgcol_sync");
        time_i = 64'd60;
        cfg(OP_HI, 2'd3, 32'd0);
        tests += 2;
        if (pending_o[3] !== 1'b0) begin fails++; $display("FAIL cfg_collision: pending_o=%b required bit3 clear", pending_o); end
        if (armed_o[3] !== 1'b1)   begin fails++; $display("FAIL cfg_col_armed: armed_o=%b required bit3 set", armed_o); end
        quiet(8, 4'b1000, "ch3_at_60");
        time_i = 64'd999;
        quiet(8, 4'b1000, "ch3_at_999");
        time_i = 64'd1000;
        wait_pend(3, 4, "ch3_fire_1000");
        ack(4'b1000);
    endtask

    task automatic test_disarm();
        time_i = 64'd1000;
        cfg(OP_LO, 2'd0, 32'd2000);
        cfg(OP_HI, 2'd0, 32'd0);
        cfg(OP_DIS, 2'd0, 32'd0);
        tests++;
        if (armed_o !== 4'b0) begin fails++; $display("FAIL disarm: armed_o=%b required 0000", armed_o); end
        time_i = 64'd3000;
        quiet(8, 4'b1111, "disarmed_quiet");
    endtask

    task automatic test_periodic();
        time_i = 64'd0;
        cfg(OP_PER, 2'd1, 32'd10);
        cfg(OP_LO, 2'd0, 32'd20);
        cfg(OP_HI, 2'd1, 32'd0);
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
        for (int k = 0; k < 3; k++) begin
            time_i = 64'(19 + 10 * k);
            quiet(8, 4'b0010, "per_early");
            time_i = 64'(20 + 10 * k);
            wait_pend(1, 4, "per_fire");
            tests++;
            if (armed_o[1] !== 1'b1) begin fails++; $display("FAIL per_armed: armed_o=%b required bit1 set", armed_o); end
            ack(4'b0010);
        end
`else
        time_i = 64'd19;
        quiet(8, 4'b0010, "oneshot_early");
        time_i = 64'd20;
        wait_pend(1, 4, "oneshot_fire");
        tests++;
        if (armed_o[1] !== 1'b0) begin fails++; $display("FAIL oneshot_armed: armed_o=%b required bit1 clear", armed_o); end
        ack(4'b0010);
        time_i = 64'd30;
        quiet(8, 4'b0010, "oneshot_no_refire");
`endif
    endtask

    initial begin
        #2;
        test_reset();
        test_arm_ch2();
        test_past_deadline();
        test_ack_collision();
        test_cfg_collision();
        test_disarm();
        test_periodic();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
